// File: rtl/dadda_mult_pipe.sv
// dadda_mult_pipe: parametrised three-stage pipelined Dadda-tree multiplier.
// Each beat is multiplied either unsigned or two's-complement (Baugh-Wooley),
// with an opaque tag carried alongside the product. A single global enable
// stalls every stage together; stages do not collapse bubbles.
`timescale 1ns/1ps

module dadda_mult_pipe #(
    parameter int WIDTH = 8,
    parameter int TAG_W = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     in_a,
    input  logic [WIDTH-1:0]     in_b,
    input  logic                 in_signed,
    input  logic [TAG_W-1:0]     in_tag,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [2*WIDTH-1:0]   out_product,
    output logic [TAG_W-1:0]     out_tag
);

    // Product width; every column of the bit matrix maps to one product bit.
    localparam int PW   = 2 * WIDTH;
    // Tallest column is WIDTH bits (partial products plus the Baugh-Wooley
    // constant); one spare slot keeps the matrix indexing in range.
    localparam int MAXH = WIDTH + 1;

    // Dadda height target for reduction stage j: 2, 3, 4, 6, 9, 13, ...
    function automatic int dadda_target(input int j);
        int d;
        d = 2;
        for (int k = 0; k < 32; k++) begin
            if (k < j) begin
                d = (d * 3) / 2;
            end
        end
        return d;
    endfunction

    // Number of reduction stages needed to bring height WIDTH down to 2.
    function automatic int dadda_stages(input int w);
        int d;
        int n;
        d = 2;
        n = 0;
        for (int k = 0; k < 32; k++) begin
            if (d < w) begin
                n = n + 1;
                d = (d * 3) / 2;
            end
        end
        return n;
    endfunction

    localparam int NSTG = dadda_stages(WIDTH);

    // Global pipeline enable: advance whenever the output slot is free or
    // being consumed this cycle.
    logic             w_en;

    logic             r_s1_valid;
    logic [WIDTH-1:0] r_s1_a;
    logic [WIDTH-1:0] r_s1_b;
    logic             r_s1_signed;
    logic [TAG_W-1:0] r_s1_tag;

    logic [PW-1:0]    w_row0;
    logic [PW-1:0]    w_row1;

    logic             r_s2_valid;
    logic [PW-1:0]    r_s2_row0;
    logic [PW-1:0]    r_s2_row1;
    logic [TAG_W-1:0] r_s2_tag;

    logic             r_out_valid;
    logic [PW-1:0]    r_out_product;
    logic [TAG_W-1:0] r_out_tag;

    assign w_en        = !r_out_valid || out_ready;
    assign in_ready    = w_en;
    assign out_valid   = r_out_valid;
    assign out_product = r_out_product;
    assign out_tag     = r_out_tag;

    // Stage 1: capture operands, mode and tag of an accepted beat.
    // NOTE: state is updated with non-blocking assignments, and the data
    // registers are reset too so outputs are a known 0 straight out of reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s1_valid  <= 1'b0;
            r_s1_a      <= '0;
            r_s1_b      <= '0;
            r_s1_signed <= 1'b0;
            r_s1_tag    <= '0;
        end else if (w_en) begin
            r_s1_valid <= in_valid;
            if (in_valid) begin
                r_s1_a      <= in_a;
                r_s1_b      <= in_b;
                r_s1_signed <= in_signed;
                r_s1_tag    <= in_tag;
            end
        end
    end

    // Partial-product matrix and Dadda reduction down to two rows.
    // NOTE: every variable is given a full default before use so this block
    // stays purely combinational (no latches).
    always_comb begin : p_dadda
        logic [PW-1:0][MAXH-1:0] cur;
        logic [PW-1:0][MAXH-1:0] nxt;
        int                      cnt  [PW];
        int                      ncnt [PW];
        int                      d;
        int                      idx;
        int                      rem;
        logic                    inv;
        logic                    x;
        logic                    y;
        logic                    z;
        logic                    sm;
        logic                    cy;
        logic                    act;

        cur    = '0;
        nxt    = '0;
        d      = 0;
        idx    = 0;
        rem    = 0;
        inv    = 1'b0;
        x      = 1'b0;
        y      = 1'b0;
        z      = 1'b0;
        sm     = 1'b0;
        cy     = 1'b0;
        act    = 1'b0;
        w_row0 = '0;
        w_row1 = '0;
        for (int c = 0; c < PW; c++) begin
            cnt[c]  = 0;
            ncnt[c] = 0;
        end

        // Partial products. In signed mode the terms pairing exactly one
        // sign bit are inverted and constant ones are added at columns WIDTH
        // and 2*WIDTH-1 (modified Baugh-Wooley); carries past the top column
        // fall away, which is the intended truncation.
        for (int i = 0; i < WIDTH; i++) begin
            for (int j = 0; j < WIDTH; j++) begin
                inv = r_s1_signed & ((i == WIDTH - 1) ^ (j == WIDTH - 1));
                cur[i+j][cnt[i+j]] = (r_s1_a[i] & r_s1_b[j]) ^ inv;
                cnt[i+j] = cnt[i+j] + 1;
            end
        end
        cur[WIDTH][cnt[WIDTH]] = r_s1_signed;
        cnt[WIDTH] = cnt[WIDTH] + 1;
        cur[PW-1][cnt[PW-1]] = r_s1_signed;
        cnt[PW-1] = cnt[PW-1] + 1;

        // Reduction stages, tallest target first. Within a column, bits are
        // compressed only while the new column (carries in + sums so far +
        // untouched bits) would still exceed the target: half adder when one
        // bit too tall, full adder otherwise.
        for (int s = NSTG - 1; s >= 0; s--) begin
            d   = dadda_target(s);
            nxt = '0;
            for (int c = 0; c < PW; c++) begin
                ncnt[c] = 0;
            end
            for (int c = 0; c < PW; c++) begin
                idx = 0;
                for (int k = 0; k < MAXH; k++) begin
                    rem = cnt[c] - idx;
                    act = 1'b0;
                    if (rem + ncnt[c] > d) begin
                        if (rem >= 3 && rem + ncnt[c] > d + 1) begin
                            x   = cur[c][idx];
                            y   = cur[c][idx+1];
                            z   = cur[c][idx+2];
                            sm  = x ^ y ^ z;
                            cy  = (x & y) | (x & z) | (y & z);
                            idx = idx + 3;
                            act = 1'b1;
                        end else if (rem >= 2) begin
                            x   = cur[c][idx];
                            y   = cur[c][idx+1];
                            sm  = x ^ y;
                            cy  = x & y;
                            idx = idx + 2;
                            act = 1'b1;
                        end
                    end
                    if (act) begin
                        nxt[c][ncnt[c]] = sm;
                        ncnt[c] = ncnt[c] + 1;
                        if (c + 1 < PW) begin
                            nxt[c+1][ncnt[c+1]] = cy;
                            ncnt[c+1] = ncnt[c+1] + 1;
                        end
                    end
                end
                // Bits not consumed by an adder pass straight through.
                for (int k = 0; k < MAXH; k++) begin
                    if (k >= idx && k < cnt[c]) begin
                        nxt[c][ncnt[c]] = cur[c][k];
                        ncnt[c] = ncnt[c] + 1;
                    end
                end
            end
            cur = nxt;
            for (int c = 0; c < PW; c++) begin
                cnt[c] = ncnt[c];
            end
        end

        // Unused slots were cleared, so slots 0/1 are the two final rows.
        for (int c = 0; c < PW; c++) begin
            w_row0[c] = cur[c][0];
            w_row1[c] = cur[c][1];
        end
    end

    // Stage 2: register the two reduced rows and the tag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s2_valid <= 1'b0;
            r_s2_row0  <= '0;
            r_s2_row1  <= '0;
            r_s2_tag   <= '0;
        end else if (w_en) begin
            r_s2_valid <= r_s1_valid;
            if (r_s1_valid) begin
                r_s2_row0 <= w_row0;
                r_s2_row1 <= w_row1;
                r_s2_tag  <= r_s1_tag;
            end
        end
    end

    // Stage 3: carry-propagate add of the two rows, truncated to 2*WIDTH.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out_valid   <= 1'b0;
            r_out_product <= '0;
            r_out_tag     <= '0;
        end else if (w_en) begin
            r_out_valid <= r_s2_valid;
            if (r_s2_valid) begin
                r_out_product <= r_s2_row0 + r_s2_row1;
                r_out_tag     <= r_s2_tag;
            end
        end
    end

endmodule

// File: tb/tb_dadda_mult_pipe.sv
// tb_dadda_mult_pipe: directed and scoreboard tests for dadda_mult_pipe at
// WIDTH 4, 8 and 16 (one instance each, index 0/1/2 in the signal arrays).
`timescale 1ns/1ps

module tb_dadda_mult_pipe;

    logic clk;
    logic rst_n;

    logic [2:0]       iv;
    logic [2:0]       ordy;
    logic [2:0]       sgn;
    logic [2:0][15:0] a;
    logic [2:0][15:0] b;
    logic [2:0][3:0]  tag;

    wire  [2:0]       irdy;
    wire  [2:0]       ov;
    wire  [2:0][3:0]  otag;
    wire  [2:0][31:0] prod;

    wire  [7:0]       prod4;
    wire  [15:0]      prod8;
    wire  [31:0]      prod16;

    int checks;
    int errors;

    assign prod[0] = {24'd0, prod4};
    assign prod[1] = {16'd0, prod8};
    assign prod[2] = prod16;

    dadda_mult_pipe #(.WIDTH(4), .TAG_W(4)) u_dut4 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv[0]), .in_ready(irdy[0]),
        .in_a(a[0][3:0]), .in_b(b[0][3:0]), .in_signed(sgn[0]), .in_tag(tag[0]),
        .out_valid(ov[0]), .out_ready(ordy[0]), .out_product(prod4), .out_tag(otag[0])
    );

    dadda_mult_pipe #(.WIDTH(8), .TAG_W(4)) u_dut8 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv[1]), .in_ready(irdy[1]),
        .in_a(a[1][7:0]), .in_b(b[1][7:0]), .in_signed(sgn[1]), .in_tag(tag[1]),
        .out_valid(ov[1]), .out_ready(ordy[1]), .out_product(prod8), .out_tag(otag[1])
    );

    dadda_mult_pipe #(.WIDTH(16), .TAG_W(4)) u_dut16 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv[2]), .in_ready(irdy[2]),
        .in_a(a[2]), .in_b(b[2]), .in_signed(sgn[2]), .in_tag(tag[2]),
        .out_valid(ov[2]), .out_ready(ordy[2]), .out_product(prod16), .out_tag(otag[2])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: exact product of w-bit operands, reduced mod 2^(2w).
    function automatic logic [31:0] ref_mul(input logic [15:0] av, input logic [15:0] bv,
                                            input logic s, input int w);
        longint      x;
        longint      y;
        longint      m;
        logic [63:0] p;
        m = (longint'(1) << w) - 1;
        x = longint'({48'd0, av}) & m;
        y = longint'({48'd0, bv}) & m;
        if (s && x[w-1]) x = x - (longint'(1) << w);
        if (s && y[w-1]) y = y - (longint'(1) << w);
        p = 64'(x * y);
        p = p & ((64'd1 << (2 * w)) - 64'd1);
        return p[31:0];
    endfunction

    // Present one beat on an idle instance and wait for its result.
    // lat counts cycles from the accept cycle to the cycle out_valid is seen.
    task automatic run_beat(input int k, input logic [15:0] av, input logic [15:0] bv,
                            input logic s, input logic [3:0] t,
                            output logic [31:0] p, output logic [3:0] ot, output int lat);
        // NOTE: bench inputs are driven with blocking assignments at the
        // negative edge so they are stable at the next rising edge.
        @(negedge clk);
        iv[k]   = 1'b1;
        a[k]    = av;
        b[k]    = bv;
        sgn[k]  = s;
        tag[k]  = t;
        ordy[k] = 1'b1;
        @(negedge clk);
        iv[k] = 1'b0;
        lat   = 1;
        while (!ov[k] && lat < 10) begin
            @(negedge clk);
            lat++;
        end
        if (!ov[k]) lat = -1;
        p  = prod[k];
        ot = otag[k];
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        iv    = '0;
        ordy  = '0;
        sgn   = '0;
        a     = '0;
        b     = '0;
        tag   = '0;
        repeat (3) @(negedge clk);
        for (int k = 0; k < 3; k++) begin
            checks++;
            if (ov[k] !== 1'b0) begin
                errors++; $display("FAIL reset_out_valid dut=%0d got=%b exp=0", k, ov[k]);
            end
            checks++;
            if (prod[k] !== 32'd0) begin
                errors++; $display("FAIL reset_product dut=%0d got=%h exp=0", k, prod[k]);
            end
            checks++;
            if (otag[k] !== 4'd0) begin
                errors++; $display("FAIL reset_tag dut=%0d got=%h exp=0", k, otag[k]);
            end
        end
        rst_n = 1'b1;
        @(negedge clk);
        for (int k = 0; k < 3; k++) begin
            checks++;
            if (irdy[k] !== 1'b1 || ov[k] !== 1'b0) begin
                errors++;
                $display("FAIL post_reset_ready dut=%0d got in_ready=%b out_valid=%b exp 1/0",
                         k, irdy[k], ov[k]);
            end
        end
    endtask

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        logic        s;
        logic [31:0] p;
    } vec_t;

    task automatic test_w4();
        vec_t        v [6];
        logic [31:0] p;
        logic [3:0]  ot;
        int          lat;
        v = '{'{16'h000F, 16'h000F, 1'b0, 32'h00E1},
              '{16'h0000, 16'h0009, 1'b0, 32'h0000},
              '{16'h0001, 16'h0001, 1'b0, 32'h0001},
              '{16'h0008, 16'h0008, 1'b1, 32'h0040},
              '{16'h0008, 16'h0007, 1'b1, 32'h00C8},
              '{16'h000F, 16'h0001, 1'b1, 32'h00FF}};
        for (int i = 0; i < 6; i++) begin
            run_beat(0, v[i].a, v[i].b, v[i].s, 4'(i + 3), p, ot, lat);
            checks++;
            if (p !== v[i].p || ot !== 4'(i + 3) || lat != 3) begin
                errors++;
                $display("FAIL w4_vec%0d got p=%h tag=%h lat=%0d exp p=%h tag=%h lat=3",
                         i, p, ot, lat, v[i].p, 4'(i + 3));
            end
        end
        for (int i = 0; i < 16; i++) begin
            for (int j = 0; j < 16; j++) begin
                run_beat(0, 16'(i), 16'(j), 1'b0, 4'(j), p, ot, lat);
                checks++;
                if (p !== 32'(i * j) || ot !== 4'(j)) begin
                    errors++;
                    $display("FAIL w4_exhaustive %0d*%0d got=%h exp=%h", i, j, p, 32'(i * j));
                end
            end
        end
    endtask

    task automatic test_w8();
        vec_t        v [5];
        logic [31:0] p;
        logic [3:0]  ot;
        int          lat;
        v = '{'{16'h00FF, 16'h00FF, 1'b0, 32'hFE01},
              '{16'h0080, 16'h0080, 1'b1, 32'h4000},
              '{16'h00FF, 16'h0001, 1'b1, 32'hFFFF},
              '{16'h0080, 16'h007F, 1'b1, 32'hC080},
              '{16'h007F, 16'h007F, 1'b1, 32'h3F01}};
        for (int i = 0; i < 5; i++) begin
            run_beat(1, v[i].a, v[i].b, v[i].s, 4'(i + 9), p, ot, lat);
            checks++;
            if (p !== v[i].p || ot !== 4'(i + 9) || lat != 3) begin
                errors++;
                $display("FAIL w8_vec%0d got p=%h tag=%h lat=%0d exp p=%h tag=%h lat=3",
                         i, p, ot, lat, v[i].p, 4'(i + 9));
            end
        end
    endtask

    task automatic test_w16();
        vec_t        v [4];
        logic [31:0] p;
        logic [3:0]  ot;
        int          lat;
        v = '{'{16'hFFFF, 16'hFFFF, 1'b0, 32'hFFFE0001},
              '{16'h8000, 16'h8000, 1'b1, 32'h40000000},
              '{16'hFFFF, 16'h0002, 1'b1, 32'hFFFFFFFE},
              '{16'h1234, 16'h5678, 1'b0, 32'h06260060}};
        for (int i = 0; i < 4; i++) begin
            run_beat(2, v[i].a, v[i].b, v[i].s, 4'(i + 1), p, ot, lat);
            checks++;
            if (p !== v[i].p || ot !== 4'(i + 1) || lat != 3) begin
                errors++;
                $display("FAIL w16_vec%0d got p=%h tag=%h lat=%0d exp p=%h tag=%h lat=3",
                         i, p, ot, lat, v[i].p, 4'(i + 1));
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] ep [100];
        logic [3:0]  et [100];
        logic [15:0] av;
        logic [15:0] bv;
        logic        s;
        for (int c = 0; c < 106; c++) begin
            @(negedge clk);
            ordy[1] = 1'b1;
            if (c >= 3 && c < 103) begin
                checks++;
                if (ov[1] !== 1'b1 || prod[1] !== ep[c-3] || otag[1] !== et[c-3]) begin
                    errors++;
                    $display("FAIL stream_beat%0d got v=%b p=%h t=%h exp v=1 p=%h t=%h",
                             c - 3, ov[1], prod[1], otag[1], ep[c-3], et[c-3]);
                end
            end else begin
                checks++;
                if (ov[1] !== 1'b0) begin
                    errors++; $display("FAIL stream_idle cycle=%0d got=%b exp=0", c, ov[1]);
                end
            end
            if (c < 100) begin
                av    = 16'($urandom_range(0, 255));
                bv    = 16'($urandom_range(0, 255));
                s     = 1'($urandom_range(0, 1));
                ep[c] = ref_mul(av, bv, s, 8);
                et[c] = 4'(c);
                iv[1] = 1'b1;
                a[1]  = av;
                b[1]  = bv;
                sgn[1] = s;
                tag[1] = 4'(c);
                #1;
                checks++;
                if (irdy[1] !== 1'b1) begin
                    errors++; $display("FAIL stream_ready cycle=%0d got=%b exp=1", c, irdy[1]);
                end
            end else begin
                iv[1] = 1'b0;
            end
        end
    endtask

    task automatic test_backpressure();
        logic [15:0] ba [4];
        logic [15:0] bb [4];
        logic        bs [4];
        logic [31:0] ep [4];
        int          nacc;
        ba = '{16'h03, 16'hFE, 16'h10, 16'h7F};
        bb = '{16'h05, 16'h03, 16'h10, 16'hFF};
        bs = '{1'b0, 1'b1, 1'b0, 1'b1};
        ep = '{32'h000F, 32'hFFFA, 32'h0100, 32'hFF81};
        nacc = 0;
        for (int c = 0; c < 7; c++) begin
            @(negedge clk);
            ordy[1] = 1'b0;
            iv[1]   = 1'b1;
            a[1]    = ba[nacc];
            b[1]    = bb[nacc];
            sgn[1]  = bs[nacc];
            tag[1]  = 4'(nacc + 4);
            #1;
            if (c >= 3) begin
                checks++;
                if (irdy[1] !== 1'b0 || ov[1] !== 1'b1 || prod[1] !== ep[0] || otag[1] !== 4'd4) begin
                    errors++;
                    $display("FAIL bp_hold cycle=%0d got rdy=%b v=%b p=%h t=%h exp 0/1/%h/4",
                             c, irdy[1], ov[1], prod[1], otag[1], ep[0]);
                end
            end
            if (irdy[1]) nacc++;
        end
        checks++;
        if (nacc != 3) begin
            errors++; $display("FAIL bp_fill got=%0d exp=3", nacc);
        end
        for (int d = 0; d < 4; d++) begin
            @(negedge clk);
            ordy[1] = 1'b1;
            iv[1]   = 1'b0;
            #1;
            checks++;
            if (d < 3) begin
                if (ov[1] !== 1'b1 || prod[1] !== ep[d] || otag[1] !== 4'(d + 4)) begin
                    errors++;
                    $display("FAIL bp_drain%0d got v=%b p=%h t=%h exp v=1 p=%h t=%h",
                             d, ov[1], prod[1], otag[1], ep[d], 4'(d + 4));
                end
            end else if (ov[1] !== 1'b0) begin
                errors++; $display("FAIL bp_empty got=%b exp=0", ov[1]);
            end
        end
    endtask

    task automatic test_reset_midstream();
        logic [15:0] ba [3];
        logic [31:0] p;
        logic [3:0]  ot;
        int          lat;
        int          nacc;
        ba = '{16'h11, 16'h22, 16'h55};
        nacc = 0;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            ordy[1] = 1'b0;
            iv[1]   = (nacc < 3);
            a[1]    = ba[nacc % 3];
            b[1]    = (nacc == 1) ? 16'h03 : ba[nacc % 3];
            sgn[1]  = 1'b0;
            tag[1]  = 4'hA;
            #1;
            if (irdy[1] && iv[1]) nacc++;
        end
        checks++;
        if (ov[1] !== 1'b1 || prod[1] !== 32'h0121) begin
            errors++; $display("FAIL rst_mid_prefill got v=%b p=%h exp v=1 p=0121", ov[1], prod[1]);
        end
        rst_n = 1'b0;
        iv[1] = 1'b0;
        #1;
        checks++;
        if (ov[1] !== 1'b0 || prod[1] !== 32'd0 || otag[1] !== 4'd0) begin
            errors++;
            $display("FAIL rst_mid_async got v=%b p=%h t=%h exp 0/0/0", ov[1], prod[1], otag[1]);
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            ordy[1] = 1'b1;
            checks++;
            if (ov[1] !== 1'b0) begin
                errors++; $display("FAIL rst_mid_stale cycle=%0d got=%b exp=0", c, ov[1]);
            end
        end
        run_beat(1, 16'h0C, 16'h0D, 1'b0, 4'h5, p, ot, lat);
        checks++;
        if (p !== 32'h009C || ot !== 4'h5 || lat != 3) begin
            errors++;
            $display("FAIL rst_mid_next got p=%h t=%h lat=%0d exp p=009c t=5 lat=3", p, ot, lat);
        end
    endtask

    task automatic test_random(input int k, input int w, input int n);
        logic [31:0] qp [$];
        logic [3:0]  qt [$];
        logic [15:0] m;
        logic [15:0] av;
        logic [15:0] bv;
        logic        s;
        logic [31:0] ep;
        logic [3:0]  et;
        logic [31:0] last_p;
        logic [3:0]  last_t;
        logic        stalled;
        int          acc;
        int          cyc;
        int          budget;
        m       = 16'((32'd1 << w) - 32'd1);
        acc     = 0;
        cyc     = 0;
        stalled = 1'b0;
        last_p  = '0;
        last_t  = '0;
        budget  = n * 10 + 100;
        while ((acc < n || qp.size() != 0) && cyc < budget) begin
            @(negedge clk);
            if (stalled) begin
                checks++;
                if (ov[k] !== 1'b1 || prod[k] !== last_p || otag[k] !== last_t) begin
                    errors++;
                    $display("FAIL rand_hold w=%0d got v=%b p=%h t=%h exp v=1 p=%h t=%h",
                             w, ov[k], prod[k], otag[k], last_p, last_t);
                end
            end
            av      = 16'($urandom) & m;
            bv      = 16'($urandom) & m;
            s       = 1'($urandom_range(0, 1));
            iv[k]   = (acc < n) && ($urandom_range(0, 3) != 0);
            a[k]    = av;
            b[k]    = bv;
            sgn[k]  = s;
            tag[k]  = 4'($urandom_range(0, 15));
            ordy[k] = ($urandom_range(0, 2) != 0);
            #1;
            if (ov[k] && ordy[k]) begin
                checks++;
                if (qp.size() == 0) begin
                    errors++; $display("FAIL rand_extra w=%0d got p=%h exp no beat", w, prod[k]);
                end else begin
                    ep = qp.pop_front();
                    et = qt.pop_front();
                    if (prod[k] !== ep || otag[k] !== et) begin
                        errors++;
                        $display("FAIL rand_beat w=%0d got p=%h t=%h exp p=%h t=%h",
                                 w, prod[k], otag[k], ep, et);
                    end
                end
            end
            if (iv[k] && irdy[k]) begin
                qp.push_back(ref_mul(av, bv, s, w));
                qt.push_back(tag[k]);
                acc++;
            end
            stalled = ov[k] && !ordy[k];
            last_p  = prod[k];
            last_t  = otag[k];
            cyc++;
        end
        checks++;
        if (acc != n || qp.size() != 0) begin
            errors++;
            $display("FAIL rand_timeout w=%0d got accepted=%0d pending=%0d exp accepted=%0d pending=0",
                     w, acc, qp.size(), n);
        end
        @(negedge clk);
        iv[k]   = 1'b0;
        ordy[k] = 1'b1;
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_w4();
        test_w8();
        test_w16();
        test_back_to_back();
        test_backpressure();
        test_reset_midstream();
        test_random(0, 4, 3400);
        test_random(1, 8, 3400);
        test_random(2, 16, 3400);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #1500000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
